vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter VRAM_WORDS, default 76800, number of valid framebuffer addresses (320x240, 8-bit 332 pixels).
REQ-002 Parameter FIFO_DEPTH, default 4, ioctl write FIFO depth; power of two, >=2.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 scan_req  in  1  one-cycle read request from the video timing path, at most one per ce_pix period.
REQ-006 scan_addr  in  17  scanout pixel address, qualified by scan_req.
REQ-007 scan_data  out  8  pixel returned to scanout.
REQ-008 scan_valid  out  1  one-cycle strobe qualifying scan_data.
REQ-009 ioctl_wr, ioctl_addr, ioctl_data  in  1/17/8  write-only HPS download port.
REQ-010 ioctl_wait  out  1  backpressure to the HPS.
REQ-011 clear_req, clear_value  in  1/8  start a framebuffer fill with clear_value (VRAM_CLEAR_EN only).
REQ-012 clear_busy, clear_done  out  1/1  fill in progress; one-cycle pulse on completion.
REQ-013 overflow  out  1  sticky flag: an ioctl write was dropped.
REQ-014 ram_addr, ram_we, ram_wdata  out  17/1/8  single-port VRAM command, registered.
REQ-015 ram_rdata  in  8  VRAM read data, one-cycle synchronous read latency.

Function
REQ-016 The block SHALL issue at most one RAM command per clk cycle; fixed priority: scan read > clear write > FIFO write.
REQ-017 A scan_req SHALL drive ram_addr=scan_addr, ram_we=0 in the following cycle; scan_valid SHALL assert exactly 2 cycles after scan_req, with scan_data = ram_rdata.
REQ-018 ioctl_wr with ioctl_addr < VRAM_WORDS SHALL push {addr,data} into the FIFO; addresses >= VRAM_WORDS SHALL be silently discarded and SHALL NOT set overflow.
REQ-019 A push SHALL be accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle; otherwise the write is dropped and overflow sets.
REQ-020 The FIFO SHALL pop one entry per cycle in which it is non-empty, no scan_req is pending, and state is IDLE; pop drives ram_we=1 with the entry's addr/data.
REQ-021 ioctl_wait SHALL be 1 when count >= FIFO_DEPTH-1 or state is CLEAR.
REQ-022 FIFO entries SHALL be written to RAM in arrival order.
REQ-023 State machine: IDLE, CLEAR. IDLE -> CLEAR on clear_req; CLEAR -> IDLE after address VRAM_WORDS-1 is written.
REQ-024 In CLEAR, a 17-bit counter SHALL start at 0 and write clear_value (latched at clear_req) to each address once, advancing only on cycles not taken by scan.
REQ-025 clear_done SHALL pulse for one cycle in the cycle after the last clear write; clear_busy SHALL be 1 from the cycle after clear_req until clear_done.
REQ-026 clear_req while in CLEAR SHALL be ignored; FIFO pushes during CLEAR are accepted and drained only after return to IDLE.
REQ-027 scan reads during CLEAR SHALL return current RAM content (partially cleared image is acceptable).

Reset
REQ-028 reset SHALL empty the FIFO, set state IDLE, counter 0, overflow 0, scan_valid 0, clear_busy 0, clear_done 0, ram_we 0, ram_addr 0, ram_wdata 0, ioctl_wait 0.
REQ-029 reset during CLEAR SHALL abort the fill with no clear_done; reset with a scan read in flight SHALL suppress its scan_valid.

Configuration
REQ-030 Macro VRAM_CLEAR_EN defined: clear engine and CLEAR state present as above.
REQ-031 VRAM_CLEAR_EN undefined: clear_req/clear_value ignored, clear_busy and clear_done tied 0, state fixed IDLE; ports remain.

Structure
REQ-032 Shared package SHALL hold VRAM_WORDS default, the 17-bit address width, and the state encoding.
REQ-033 The FIFO SHALL be a sub-module named vram_wr_fifo (parameterised depth, count output); arbitration and clear FSM stay in vram_arbiter.

Verification
REQ-034 scan_req, scan_addr=5, RAM[5]=8'hE3 -> ram_addr=5 with ram_we=0 next cycle; scan_valid with scan_data=8'hE3 2 cycles after scan_req.
REQ-035 Five back-to-back ioctl writes (addr 0..4, data 8'h10..8'h14) while scan_req is held every cycle -> ioctl_wait high at count 3; fifth write dropped; overflow=1; after scan_req stops, RAM[0..3]=8'h10..8'h13 written in order.
REQ-036 ioctl_wr to addr 76800 -> no RAM write, overflow stays 0.
REQ-037 clear_req with clear_value=8'h00 plus scan_req every 4th cycle -> 76800 clear writes, clear_done exactly once, no scan read lost, ioctl_wait high throughout.
REQ-038 reset asserted at clear counter 1000 -> clear_busy=0 next cycle, no clear_done, a subsequent clear_req restarts at address 0.
REQ-039 Build without VRAM_CLEAR_EN, pulse clear_req -> no RAM writes, clear_busy/clear_done stay 0.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: framebuffer size, address width, FSM encoding.
package vram_arbiter_pkg;

    localparam int unsigned VRAM_WORDS_DEFAULT = 76800;
    localparam int unsigned VRAM_AW            = 17;
    localparam int unsigned PIX_W              = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Write FIFO for HPS download entries; the caller guarantees no push when full without a pop.
module vram_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 25,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // When full with a simultaneous pop, the slot is read this cycle before it is overwritten.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads > clear fill > buffered HPS writes.
// Define VRAM_CLEAR_EN to build the framebuffer clear engine.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned VRAM_WORDS = VRAM_WORDS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_req,
    input  logic [VRAM_AW-1:0] scan_addr,
    output logic [PIX_W-1:0]   scan_data,
    output logic               scan_valid,
    input  logic               ioctl_wr,
    input  logic [VRAM_AW-1:0] ioctl_addr,
    input  logic [PIX_W-1:0]   ioctl_data,
    output logic               ioctl_wait,
    input  logic               clear_req,
    input  logic [PIX_W-1:0]   clear_value,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               overflow,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic               ram_we,
    output logic [PIX_W-1:0]   ram_wdata,
    input  logic [PIX_W-1:0]   ram_rdata
);
    localparam int unsigned        CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned        ENTRY_W  = VRAM_AW + PIX_W;
    localparam logic [VRAM_AW-1:0] WORDS_C  = VRAM_AW'(VRAM_WORDS);
    localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);

    arb_state_e         state_q;
    logic [VRAM_AW-1:0] clr_cnt_q;
    logic [PIX_W-1:0]   clr_val_q;
    logic               clr_done_q;
    logic               clr_wr;

    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               wr_in_range;
    logic               fifo_push;
    logic               fifo_pop;

    logic               overflow_q, overflow_d;
    logic               scan_s1_q, scan_s2_q;
    logic [VRAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic [PIX_W-1:0]   ram_wdata_q, ram_wdata_d;

`ifdef VRAM_CLEAR_EN
    localparam logic [VRAM_AW-1:0] LAST_ADDR = VRAM_AW'(VRAM_WORDS - 1);

    arb_state_e         state_d;
    logic [VRAM_AW-1:0] clr_cnt_d;
    logic [PIX_W-1:0]   clr_val_d;
    logic               clr_done_d;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_val_d  = clr_val_q;
        clr_done_d = 1'b0;
        clr_wr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    clr_val_d = clear_value;
                end
            end
            ST_CLEAR: begin
                // Scan reads steal the port; the fill simply resumes on the next free cycle.
                if (!scan_req) begin
                    clr_wr = 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d    = ST_IDLE;
                        clr_cnt_d  = '0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + VRAM_AW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            clr_val_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_val_q  <= clr_val_d;
            clr_done_q <= clr_done_d;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = ^{clear_req, clear_value};
    assign state_q      = ST_IDLE;
    assign clr_cnt_q    = '0;
    assign clr_val_q    = '0;
    assign clr_done_q   = 1'b0;
    assign clr_wr       = 1'b0;
`endif

    assign wr_in_range = (ioctl_addr < WORDS_C);
    assign fifo_pop    = (fifo_count != '0) && !scan_req && (state_q == ST_IDLE);
    assign fifo_push   = ioctl_wr && wr_in_range && ((fifo_count < DEPTH_C) || fifo_pop);
    assign overflow_d  = overflow_q | (ioctl_wr & wr_in_range & ~fifo_push);

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({ioctl_addr, ioctl_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (scan_req) begin
            ram_addr_d = scan_addr;
        end else if (clr_wr) begin
            ram_addr_d  = clr_cnt_q;
            ram_we_d    = 1'b1;
            ram_wdata_d = clr_val_q;
        end else if (fifo_pop) begin
            ram_addr_d  = fifo_rdata[ENTRY_W-1:PIX_W];
            ram_we_d    = 1'b1;
            ram_wdata_d = fifo_rdata[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            overflow_q  <= 1'b0;
            scan_s1_q   <= 1'b0;
            scan_s2_q   <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            overflow_q  <= overflow_d;
            scan_s1_q   <= scan_req;
            scan_s2_q   <= scan_s1_q;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign scan_valid = scan_s2_q;
    assign scan_data  = ram_rdata;
    assign overflow   = overflow_q;
    assign ioctl_wait = (fifo_count >= DEPTH_M1) || (state_q == ST_CLEAR);
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = clr_done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural one-cycle-latency VRAM.
// Clear-engine scenarios are compiled when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;
    // Reduced framebuffer keeps the full-fill scenario short.
    localparam int WORDS = 2000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_req;
    logic [16:0] scan_addr;
    logic [7:0]  scan_data;
    logic        scan_valid;
    logic        ioctl_wr;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic        clear_req;
    logic [7:0]  clear_value;
    logic        clear_busy;
    logic        clear_done;
    logic        overflow;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .VRAM_WORDS (WORDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .scan_valid  (scan_valid),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wait  (ioctl_wait),
        .clear_req   (clear_req),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .overflow    (overflow),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Behavioural VRAM plus a log of every write command, in issue order.
    logic [7:0]  mem [0:131071];
    logic [24:0] wlog [$];
    logic        pre_we = 1'b0;
    logic [16:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic        fill_go = 1'b0;
    logic [7:0]  fill_val = '0;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wlog.push_back({ram_addr, ram_wdata});
        end
        if (pre_we) mem[pre_addr] <= pre_data;
        if (fill_go) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= fill_val;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        scan_req    = 1'b0;
        scan_addr   = '0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_data  = '0;
        clear_req   = 1'b0;
        clear_value = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pre_write(input logic [16:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid got %b want 0", scan_valid); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        checks++; if (ram_addr !== 17'd0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        checks++; if (ram_wdata !== 8'd0) begin errors++; $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_ioctl_wait got %b want 0", ioctl_wait); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy got %b want 0", clear_busy); end
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got %b want 0", clear_done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_scan();
        pre_write(17'd5, 8'hE3);
        pre_write(17'd6, 8'h81);
        pre_write(17'(WORDS - 1), 8'h3C);
        scan_req  = 1'b1;
        scan_addr = 17'd5;
        tick();
        checks++; if (ram_addr !== 17'd5) begin errors++; $display("FAIL scan_ram_addr got %h want 5", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL scan_ram_we got %b want 0", ram_we); end
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_early got %b want 0", scan_valid); end
        scan_addr = 17'd6;
        tick();
        scan_req = 1'b0;
        checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL scan_valid_first got %b want 1", scan_valid); end
        checks++; if (scan_data !== 8'hE3) begin errors++; $display("FAIL scan_data_first got %h want e3", scan_data); end
        tick();
        checks++; if (scan_valid !== 1'b1 || scan_data !== 8'h81) begin errors++; $display("FAIL scan_second got valid=%b data=%h want 1/81", scan_valid, scan_data); end
        tick();
        checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_drop got %b want 0", scan_valid); end
        scan_req  = 1'b1;
        scan_addr = 17'(WORDS - 1);
        tick();
        scan_req = 1'b0;
        tick();
        checks++; if (scan_valid !== 1'b1 || scan_data !== 8'h3C) begin errors++; $display("FAIL scan_last_addr got valid=%b data=%h want 1/3c", scan_valid, scan_data); end
        tick();
    endtask

    task automatic test_fifo_overflow();
        int base;
        logic [24:0] exp_e [5];
        do_reset();
        base      = wlog.size();
        scan_req  = 1'b1;
        scan_addr = 17'd100;
        for (int i = 0; i < 5; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 17'(i);
            ioctl_data = 8'h10 + 8'(i);
            tick();
            checks++; if (ioctl_wait !== (i >= 2)) begin errors++; $display("FAIL ovf_wait_%0d got %b want %b", i, ioctl_wait, (i >= 2)); end
            checks++; if (overflow !== (i == 4)) begin errors++; $display("FAIL ovf_flag_%0d got %b want %b", i, overflow, (i == 4)); end
        end
        ioctl_wr = 1'b0;
        tick();
        checks++; if (wlog.size() != base) begin errors++; $display("FAIL ovf_no_write_under_scan got %0d writes want 0", wlog.size() - base); end
        // Full FIFO with a pop in the same cycle still accepts this write.
        scan_req   = 1'b0;
        ioctl_wr   = 1'b1;
        ioctl_addr = 17'd7;
        ioctl_data = 8'h17;
        tick();
        ioctl_wr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        exp_e = '{{17'd0, 8'h10}, {17'd1, 8'h11}, {17'd2, 8'h12}, {17'd3, 8'h13}, {17'd7, 8'h17}};
        checks++; if (wlog.size() - base != 5) begin errors++; $display("FAIL ovf_write_count got %0d want 5", wlog.size() - base); end
        for (int i = 0; i < 5; i++) begin
            if (base + i < wlog.size()) begin
                checks++; if (wlog[base + i] !== exp_e[i]) begin errors++; $display("FAIL ovf_order_%0d got %h want %h", i, wlog[base + i], exp_e[i]); end
            end
        end
        checks++; if (mem[3] !== 8'h13) begin errors++; $display("FAIL ovf_ram3 got %h want 13", mem[3]); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL ovf_wait_drained got %b want 0", ioctl_wait); end
    endtask

    task automatic test_out_of_range();
        int base;
        logic [16:0] addrs [4];
        do_reset();
        base  = wlog.size();
        addrs = '{17'(WORDS), 17'd76800, 17'h1FFFF, 17'(WORDS - 1)};
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = addrs[i];
            ioctl_data = 8'h60 + 8'(i);
            tick();
        end
        ioctl_wr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (wlog.size() - base != 1) begin errors++; $display("FAIL oor_write_count got %0d want 1", wlog.size() - base); end
        if (wlog.size() > base) begin
            checks++; if (wlog[base] !== {17'(WORDS - 1), 8'h63}) begin errors++; $display("FAIL oor_edge_write got %h want %h", wlog[base], {17'(WORDS - 1), 8'h63}); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oor_overflow got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = wlog.size();
        for (int i = 0; i < 8; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 17'd20 + 17'(i);
            ioctl_data = 8'hA0 + 8'(i);
            tick();
            checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL b2b_wait_%0d got %b want 0", i, ioctl_wait); end
        end
        ioctl_wr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (wlog.size() - base != 8) begin errors++; $display("FAIL b2b_write_count got %0d want 8", wlog.size() - base); end
        for (int i = 0; i < 8; i++) begin
            if (base + i < wlog.size()) begin
                checks++; if (wlog[base + i] !== {17'd20 + 17'(i), 8'hA0 + 8'(i)}) begin errors++; $display("FAIL b2b_order_%0d got %h want %h", i, wlog[base + i], {17'd20 + 17'(i), 8'hA0 + 8'(i)}); end
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    endtask

`ifdef VRAM_CLEAR_EN
    task automatic test_clear();
        int base, k, post, done_cnt, scans, valids, wait_bad, data_bad;
        bit done_seen;
        do_reset();
        fill_val = 8'hA5;
        fill_go  = 1'b1;
        tick();
        fill_go = 1'b0;
        base        = wlog.size();
        clear_value = 8'h00;
        clear_req   = 1'b1;
        tick();
        clear_req   = 1'b0;
        clear_value = 8'hFF;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_start got %b want 1", clear_busy); end
        checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL clr_wait_start got %b want 1", ioctl_wait); end
        k = 0; post = 0; done_cnt = 0; scans = 0; valids = 0; wait_bad = 0; done_seen = 0;
        while (k < 4 * WORDS && post < 10) begin
            scan_req   = !done_seen && (k % 4 == 0);
            scan_addr  = 17'(k % WORDS);
            ioctl_wr   = (k == 50);
            ioctl_addr = 17'd10;
            ioctl_data = 8'h77;
            clear_req  = (k == 200);
            if (scan_req) scans++;
            tick();
            if (scan_valid) valids++;
            if (clear_done) begin done_cnt++; done_seen = 1; end
            if (clear_busy && !ioctl_wait) wait_bad++;
            if (done_seen) post++;
            k++;
        end
        idle_inputs();
        checks++; if (!done_seen) begin errors++; $display("FAIL clr_timeout got no clear_done within %0d cycles", 4 * WORDS); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_count got %0d want 1", done_cnt); end
        checks++; if (valids != scans) begin errors++; $display("FAIL clr_scan_lost got %0d valids want %0d", valids, scans); end
        checks++; if (wait_bad != 0) begin errors++; $display("FAIL clr_wait_low got %0d cycles want 0", wait_bad); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_end got %b want 0", clear_busy); end
        checks++; if (wlog.size() - base != WORDS + 1) begin errors++; $display("FAIL clr_write_count got %0d want %0d", wlog.size() - base, WORDS + 1); end
        data_bad = 0;
        for (int j = 0; j < WORDS; j++) begin
            if (base + j >= wlog.size() || wlog[base + j] !== {17'(j), 8'h00}) data_bad++;
        end
        checks++; if (data_bad != 0) begin errors++; $display("FAIL clr_sequence got %0d bad writes want 0", data_bad); end
        if (base + WORDS < wlog.size()) begin
            checks++; if (wlog[base + WORDS] !== {17'd10, 8'h77}) begin errors++; $display("FAIL clr_fifo_after got %h want %h", wlog[base + WORDS], {17'd10, 8'h77}); end
        end
        checks++; if (mem[10] !== 8'h77 || mem[WORDS - 1] !== 8'h00) begin errors++; $display("FAIL clr_ram got m10=%h mlast=%h want 77/00", mem[10], mem[WORDS - 1]); end
    endtask

    task automatic test_clear_reset();
        int base, done_bad;
        bit found;
        do_reset();
        clear_value = 8'h5A;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        found = 0;
        for (int k = 0; k < 3 * WORDS && !found; k++) begin
            tick();
            if (ram_we && ram_addr == 17'd1000) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL clrrst_reach got no write at 1000 want write"); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clrrst_busy got %b want 0", clear_busy); end
        done_bad = (clear_done !== 1'b0) ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (clear_done !== 1'b0 || clear_busy !== 1'b0) done_bad++;
        end
        checks++; if (done_bad != 0) begin errors++; $display("FAIL clrrst_no_done got %0d bad cycles want 0", done_bad); end
        base        = wlog.size();
        clear_value = 8'h3C;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clrrst_restart_busy got %b want 1", clear_busy); end
        tick();
        tick();
        tick();
        checks++; if (wlog.size() <= base || wlog[base] !== {17'd0, 8'h3C}) begin errors++; $display("FAIL clrrst_restart_addr got %0d entries first=%h want %h", wlog.size() - base, (wlog.size() > base) ? wlog[base] : 25'h0, {17'd0, 8'h3C}); end
        do_reset();
    endtask
`else
    task automatic test_no_clear();
        int base, bad;
        do_reset();
        base        = wlog.size();
        clear_value = 8'h99;
        clear_req   = 1'b1;
        tick();
        clear_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (clear_busy !== 1'b0 || clear_done !== 1'b0 || ioctl_wait !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL noclr_flags got %0d bad cycles want 0", bad); end
        checks++; if (wlog.size() != base) begin errors++; $display("FAIL noclr_writes got %0d want 0", wlog.size() - base); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_scan();
        test_fifo_overflow();
        test_out_of_range();
        test_back_to_back();
`ifdef VRAM_CLEAR_EN
        test_clear();
        test_clear_reset();
`else
        test_no_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
